// File: rtl/mux_pkg.sv
// Shared definitions for the 4-to-1 collector: channel codes, FSM encoding, stat width.
package mux_pkg;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  localparam int STAT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin: search starts at ptr+1 and wraps, so ptr itself has lowest priority.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Walk from farthest (ptr) to nearest (ptr+1); the last hit is the winner.
  always_comb begin
    grant_o = '0;
    idx_o   = CH0;
    cand    = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        grant_o = 4'b0001 << cand;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/four_to_one_mux_arbiter.sv
// Merges four valid/ready channels into one registered stream tagged with the demux channel code.
// Optional per-channel saturating transfer counters under `define MUX_STATS_EN.
module four_to_one_mux_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [DATA_W-1:0]     in_data0,
  input  logic [DATA_W-1:0]     in_data1,
  input  logic [DATA_W-1:0]     in_data2,
  input  logic [DATA_W-1:0]     in_data3,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
`ifdef MUX_STATS_EN
  output logic [4*STAT_W-1:0]   stat_cnt,
`endif
  input  logic                  out_ready
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        grant;
  logic [1:0]        gnt_idx;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter4 u_arb (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx)
  );

  assign load     = (state_q == EMPTY) | out_ready;
  assign in_ready = rst ? 4'b0000 : (grant & {4{load}});
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    case (gnt_idx)
      CH0:     gnt_data = in_data0;
      CH1:     gnt_data = in_data1;
      CH2:     gnt_data = in_data2;
      default: gnt_data = in_data3;
    endcase
  end

  // A loading cycle with no transfer drains to EMPTY; data/sel keep their last values.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) state_d = xfer ? FULL : EMPTY;
    if (xfer) begin
      data_d = gnt_data;
      sel_d  = gnt_idx;
      ptr_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= CH0;
      ptr_q   <= CH3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef MUX_STATS_EN
  logic [3:0][STAT_W-1:0] cnt_q;

  for (genvar i = 0; i < 4; i++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst)
        cnt_q[i] <= '0;
      else if (in_valid[i] && in_ready[i] && (cnt_q[i] != {STAT_W{1'b1}}))
        cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_four_to_one_mux_arbiter.sv
// Directed self-checking bench for four_to_one_mux_arbiter (stats checks under MUX_STATS_EN).
module tb_four_to_one_mux_arbiter;
  import mux_pkg::*;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid;
  logic [DATA_W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]        in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic              out_ready;
`ifdef MUX_STATS_EN
  logic [4*STAT_W-1:0] stat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  four_to_one_mux_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef MUX_STATS_EN
    .stat_cnt  (stat_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data0 = 8'h01; in_data1 = 8'h02; in_data2 = 8'h03; in_data3 = 8'h04;
    step();
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (out_sel !== 2'b00) begin bad++; $display("FAIL reset_out_sel got=%b exp=00", out_sel); end
    rst = 1'b0; in_valid = 4'b0000;
    #1;
  endtask

  task automatic test_single();
    in_valid = 4'b0100; in_data2 = 8'hA5; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    step();
    in_valid = 4'b0000;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    total++; if (out_sel !== CH2) begin bad++; $display("FAIL single_out_sel got=%b exp=10", out_sel); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL single_in_ready_after got=%b exp=0000", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_drain_hold got=%h exp=a5", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sel;
    do_reset();
    in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_sel = 2'(k);
      #1;
      total++; if (in_ready !== (4'b0001 << exp_sel)) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << exp_sel); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, out_valid); end
      total++; if (out_sel !== exp_sel) begin bad++; $display("FAIL stream_sel[%0d] got=%b exp=%b", k, out_sel, exp_sel); end
      total++; if (out_data !== (8'h10 + 8'(exp_sel))) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, out_data, 8'h10 + 8'(exp_sel)); end
    end
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0001; in_data0 = 8'h33; out_ready = 1'b1;
    step();
    in_valid = 4'b0010; in_data1 = 8'h44; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_sel !== CH0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/33/00", k, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    step();
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h44 || out_sel !== CH1) begin
      bad++; $display("FAIL bp_release_word got=%b/%h/%b exp=1/44/01", out_valid, out_data, out_sel);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [4];
    exp_seq = '{CH0, CH3, CH0, CH3};
    do_reset();
    in_data0 = 8'hA0; in_data3 = 8'hA3;
    in_valid = 4'b1001; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (out_sel !== exp_seq[k] || out_data !== ((exp_seq[k] == CH0) ? 8'hA0 : 8'hA3)) begin
        bad++; $display("FAIL wrap[%0d] got=%b/%h exp_sel=%b", k, out_sel, out_data, exp_seq[k]);
      end
    end
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'b0100; in_data2 = 8'h5A; out_ready = 1'b1;
    step();
    in_valid = 4'b0000; out_ready = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin bad++; $display("FAIL mid_pre got=%b/%h exp=1/5a", out_valid, out_data); end
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", in_ready); end
    step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_sel !== 2'b00 || out_data !== 8'h00) begin
      bad++; $display("FAIL mid_after got=%b/%b/%h exp=0/00/00", out_valid, out_sel, out_data);
    end
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", in_ready); end
    in_valid = 4'b0000;
    step();
  endtask

`ifdef MUX_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b1000;
    repeat (300) step();
    in_valid = 4'b0001;
    repeat (2) step();
    in_valid = 4'b0000;
    #1;
    total++; if (stat_cnt !== {8'd255, 8'd0, 8'd0, 8'd2}) begin bad++; $display("FAIL stats_count got=%h exp=ff000002", stat_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (stat_cnt !== 32'h0) begin bad++; $display("FAIL stats_clear got=%h exp=00000000", stat_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef MUX_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
